// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS instruction-fetch stage: PC, IF/ID register, BOOT/RUN/HALT control
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   imem_addr / imem_data    word address out, combinational instruction word back
//   stall                    hold PC, IF/ID register and fetch_count
//   redirect_valid/_pc       load new PC (low 2 bits cleared), squash current fetch
//   halt                     stop fetching until a redirect
//   if_id_valid/_inst/_pc/_pc4  IF/ID pipeline register toward decode
//   pc, fetch_count, halted  status
//   align_exc                only with FETCH_ALIGN_EXC_EN: marks the first
//                            instruction after a misaligned redirect
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        if_id_valid,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] pc,
    output logic [31:0] fetch_count,
`ifdef FETCH_ALIGN_EXC_EN
    output logic        align_exc,
`endif
    output logic        halted
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic        load_redirect;
    logic        do_fetch;
    logic        do_bubble;
    logic [31:0] redirect_aligned;

    // Masking keeps every redirect_pc bit in use and drops the byte offset.
    assign redirect_aligned = redirect_pc & ~32'd3;

    // Depends on pc alone, so the memory address only moves when pc moves.
    assign imem_addr = {2'b00, pc[31:2]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN: begin
                if (redirect_valid)  state_next = RUN;
                else if (stall)      state_next = RUN;
                else if (halt)       state_next = HALT;
                else                 state_next = RUN;
            end
            HALT:    state_next = redirect_valid ? RUN : HALT;
            default: state_next = BOOT;
        endcase
    end

    // Control strobes for the datapath; priority redirect > stall > halt > fetch.
    always_comb begin
        halted        = 1'b0;
        load_redirect = 1'b0;
        do_fetch      = 1'b0;
        do_bubble     = 1'b0;
        case (state)
            BOOT: begin
                load_redirect = redirect_valid;
            end
            RUN: begin
                if (redirect_valid) begin
                    load_redirect = 1'b1;
                    do_bubble     = 1'b1;
                end else if (stall) begin
                    do_bubble     = 1'b0;
                end else if (halt) begin
                    do_bubble     = 1'b1;
                end else begin
                    do_fetch      = 1'b1;
                end
            end
            HALT: begin
                halted        = 1'b1;
                do_bubble     = 1'b1;
                load_redirect = redirect_valid;
            end
            default: begin
                halted = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_WORD;
            if_id_pc    <= 32'd0;
            if_id_pc4   <= 32'd0;
            fetch_count <= 32'd0;
        end else begin
            if (load_redirect) begin
                pc <= redirect_aligned;
            end else if (do_fetch) begin
                pc <= pc + 32'd4;
            end

            if (do_fetch) begin
                if_id_valid <= 1'b1;
                if_id_inst  <= imem_data;
                if_id_pc    <= pc;
                if_id_pc4   <= pc + 32'd4;
                fetch_count <= fetch_count + 32'd1;
            end else if (do_bubble) begin
                // if_id_pc/if_id_pc4 deliberately hold through bubbles.
                if_id_valid <= 1'b0;
                if_id_inst  <= NOP_WORD;
            end
        end
    end

`ifdef FETCH_ALIGN_EXC_EN
    // Remembers that the pending fetch target came from a misaligned redirect;
    // a later redirect overwrites it, the next real fetch consumes it.
    logic align_pend;

    always_ff @(posedge clk) begin
        if (rst) begin
            align_pend <= 1'b0;
            align_exc  <= 1'b0;
        end else begin
            if (load_redirect) begin
                align_pend <= |redirect_pc[1:0];
            end else if (do_fetch) begin
                align_pend <= 1'b0;
            end

            if (do_fetch) begin
                align_exc <= align_pend;
            end else if (do_bubble) begin
                align_exc <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;

    logic [31:0] imem_addr, imem_data, if_id_inst, if_id_pc, if_id_pc4, pc, fetch_count;
    logic        if_id_valid, halted;
    logic [31:0] imem_addr2, imem_data2, if_id_inst2, if_id_pc2, if_id_pc4_2, pc2, fetch_count2;
    logic        if_id_valid2, halted2;
`ifdef FETCH_ALIGN_EXC_EN
    logic        align_exc, align_exc2;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Instruction memory: word i holds 32'h1000_0000 + i.
    assign imem_data  = 32'h1000_0000 + imem_addr;
    assign imem_data2 = 32'h1000_0000 + imem_addr2;

    fetch_stage dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .if_id_valid(if_id_valid), .if_id_inst(if_id_inst),
        .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4), .pc(pc),
        .fetch_count(fetch_count),
`ifdef FETCH_ALIGN_EXC_EN
        .align_exc(align_exc),
`endif
        .halted(halted)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .imem_addr(imem_addr2), .imem_data(imem_data2),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt(halt), .if_id_valid(if_id_valid2), .if_id_inst(if_id_inst2),
        .if_id_pc(if_id_pc2), .if_id_pc4(if_id_pc4_2), .pc(pc2),
        .fetch_count(fetch_count2),
`ifdef FETCH_ALIGN_EXC_EN
        .align_exc(align_exc2),
`endif
        .halted(halted2)
    );

    typedef struct {
        logic        rst, stall, rv;
        logic [31:0] rpc;
        logic        halt;
        logic [31:0] e_pc;
        logic        e_valid;
        logic [31:0] e_inst, e_ifpc, e_ifpc4, e_cnt;
        logic        e_halted;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic s, input logic rv, input logic [31:0] rpc,
                       input logic h, input logic [31:0] epc, input logic ev,
                       input logic [31:0] einst, input logic [31:0] eifpc,
                       input logic [31:0] eifpc4, input logic [31:0] ecnt, input logic eh);
        vec_t v;
        v.rst = r; v.stall = s; v.rv = rv; v.rpc = rpc; v.halt = h;
        v.e_pc = epc; v.e_valid = ev; v.e_inst = einst; v.e_ifpc = eifpc;
        v.e_ifpc4 = eifpc4; v.e_cnt = ecnt; v.e_halted = eh;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rv,
                        input logic [31:0] rpc, input logic h);
        rst = r; stall = s; redirect_valid = rv; redirect_pc = rpc; halt = h;
        @(posedge clk);
        #1;
    endtask

    // Behavioural reference state
    logic [31:0] m_pc, m_inst, m_ifpc, m_ifpc4, m_cnt;
    logic        m_valid, m_halted, m_boot;

    function automatic logic [31:0] mem_word(input logic [31:0] byte_addr);
        return 32'h1000_0000 + (byte_addr >> 2);
    endfunction

    task automatic model_step(input logic r, input logic s, input logic rv,
                              input logic [31:0] rpc, input logic h);
        if (r) begin
            m_pc = 32'd0; m_inst = NOP; m_ifpc = 0; m_ifpc4 = 0; m_cnt = 0;
            m_valid = 0; m_halted = 0; m_boot = 1;
        end else if (m_boot) begin
            if (rv) m_pc = {rpc[31:2], 2'b00};
            m_boot = 0;
        end else if (m_halted) begin
            m_valid = 0; m_inst = NOP;
            if (rv) begin
                m_pc = {rpc[31:2], 2'b00};
                m_halted = 0;
            end
        end else if (rv) begin
            m_pc = {rpc[31:2], 2'b00}; m_valid = 0; m_inst = NOP;
        end else if (s) begin
            m_pc = m_pc;
        end else if (h) begin
            m_halted = 1; m_valid = 0; m_inst = NOP;
        end else begin
            m_ifpc = m_pc; m_ifpc4 = m_pc + 4; m_inst = mem_word(m_pc);
            m_valid = 1; m_pc = m_pc + 4; m_cnt = m_cnt + 1;
        end
    endtask

    initial begin
        // Directed table (RESET_PC = 0)
        add(1,0,0,32'h00,0, 32'h00,0,NOP,         32'h00,32'h00,0,0);
        add(0,0,0,32'h00,0, 32'h00,0,NOP,         32'h00,32'h00,0,0);
        add(0,0,0,32'h00,0, 32'h04,1,32'h10000000,32'h00,32'h04,1,0);
        add(0,0,0,32'h00,0, 32'h08,1,32'h10000001,32'h04,32'h08,2,0);
        add(0,1,0,32'h00,0, 32'h08,1,32'h10000001,32'h04,32'h08,2,0);
        add(0,1,0,32'h00,0, 32'h08,1,32'h10000001,32'h04,32'h08,2,0);
        add(0,1,0,32'h00,0, 32'h08,1,32'h10000001,32'h04,32'h08,2,0);
        add(0,0,0,32'h00,0, 32'h0C,1,32'h10000002,32'h08,32'h0C,3,0);
        add(0,1,1,32'h40,0, 32'h40,0,NOP,         32'h08,32'h0C,3,0);
        add(0,0,0,32'h00,0, 32'h44,1,32'h10000010,32'h40,32'h44,4,0);
        add(0,0,1,32'h10,0, 32'h10,0,NOP,         32'h40,32'h44,4,0);
        add(0,0,0,32'h00,1, 32'h10,0,NOP,         32'h40,32'h44,4,1);
        add(0,1,0,32'h00,0, 32'h10,0,NOP,         32'h40,32'h44,4,1);
        add(0,0,0,32'h00,1, 32'h10,0,NOP,         32'h40,32'h44,4,1);
        add(0,1,0,32'h00,1, 32'h10,0,NOP,         32'h40,32'h44,4,1);
        add(0,0,0,32'h00,0, 32'h10,0,NOP,         32'h40,32'h44,4,1);
        add(0,1,1,32'h80,1, 32'h80,0,NOP,         32'h40,32'h44,4,0);
        add(0,0,0,32'h00,0, 32'h84,1,32'h10000020,32'h80,32'h84,5,0);
        add(0,0,1,32'h43,0, 32'h40,0,NOP,         32'h80,32'h84,5,0);
        add(0,0,0,32'h00,0, 32'h44,1,32'h10000010,32'h40,32'h44,6,0);
        add(1,1,0,32'h00,1, 32'h00,0,NOP,         32'h00,32'h00,0,0);
        add(0,0,1,32'h20,0, 32'h20,0,NOP,         32'h00,32'h00,0,0);
        add(0,0,0,32'h00,0, 32'h24,1,32'h10000008,32'h20,32'h24,1,0);
        add(0,0,0,32'h00,1, 32'h24,0,NOP,         32'h20,32'h24,1,1);
        add(1,0,0,32'h00,0, 32'h00,0,NOP,         32'h00,32'h00,0,0);
        add(0,0,0,32'h00,0, 32'h00,0,NOP,         32'h00,32'h00,0,0);
        add(0,0,0,32'h00,0, 32'h04,1,32'h10000000,32'h00,32'h04,1,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].stall, tbl[i].rv, tbl[i].rpc, tbl[i].halt);
            chk($sformatf("tbl%0d pc", i),        pc,          tbl[i].e_pc);
            chk($sformatf("tbl%0d imem_addr", i), imem_addr,   tbl[i].e_pc >> 2);
            chk($sformatf("tbl%0d valid", i),     {31'd0, if_id_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("tbl%0d inst", i),      if_id_inst,  tbl[i].e_inst);
            chk($sformatf("tbl%0d if_pc", i),     if_id_pc,    tbl[i].e_ifpc);
            chk($sformatf("tbl%0d if_pc4", i),    if_id_pc4,   tbl[i].e_ifpc4);
            chk($sformatf("tbl%0d count", i),     fetch_count, tbl[i].e_cnt);
            chk($sformatf("tbl%0d halted", i),    {31'd0, halted}, {31'd0, tbl[i].e_halted});
        end

        // PC wrap on the RESET_PC = FFFF_FFFC instance
        step(1,0,0,0,0);
        chk("wrap reset pc", pc2, 32'hFFFF_FFFC);
        chk("wrap reset imem_addr", imem_addr2, 32'h3FFF_FFFF);
        step(0,0,0,0,0);
        chk("wrap boot valid", {31'd0, if_id_valid2}, 32'd0);
        chk("wrap boot pc", pc2, 32'hFFFF_FFFC);
        step(0,0,0,0,0);
        chk("wrap d1 if_pc", if_id_pc2, 32'hFFFF_FFFC);
        chk("wrap d1 if_pc4", if_id_pc4_2, 32'h0000_0000);
        chk("wrap d1 inst", if_id_inst2, 32'h4FFF_FFFF);
        chk("wrap d1 pc", pc2, 32'h0000_0000);
        chk("wrap d1 count", fetch_count2, 32'd1);
        chk("wrap d1 halted", {31'd0, halted2}, 32'd0);
        step(0,0,0,0,0);
        chk("wrap d2 if_pc", if_id_pc2, 32'h0000_0000);
        chk("wrap d2 valid", {31'd0, if_id_valid2}, 32'd1);

`ifdef FETCH_ALIGN_EXC_EN
        step(1,0,0,0,0);
        chk("align reset", {31'd0, align_exc}, 32'd0);
        step(0,0,0,0,0);
        step(0,0,0,0,0);
        step(0,0,1,32'h42,0);
        chk("align redirect pc", pc, 32'h40);
        chk("align redirect flag", {31'd0, align_exc}, 32'd0);
        step(0,1,0,0,0);
        chk("align stall flag", {31'd0, align_exc}, 32'd0);
        step(0,0,0,0,0);
        chk("align d1 flag", {31'd0, align_exc}, 32'd1);
        chk("align d1 if_pc", if_id_pc, 32'h40);
        chk("align d1 valid", {31'd0, if_id_valid}, 32'd1);
        step(0,0,0,0,0);
        chk("align d2 flag", {31'd0, align_exc}, 32'd0);
`endif

        // Randomized run against the behavioural model
        step(1,0,0,0,0);
        model_step(1,0,0,0,0);
        for (int c = 0; c < 600; c++) begin
            logic        r, s, rv, h;
            logic [31:0] rpc;
            r   = ($urandom_range(0, 59) == 0);
            s   = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 7) == 0);
            h   = ($urandom_range(0, 9) == 0);
            rpc = $urandom_range(0, 32'h3FF);
            if ($urandom_range(0, 15) == 0) rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            step(r, s, rv, rpc, h);
            model_step(r, s, rv, rpc, h);
            chk($sformatf("rnd%0d pc", c),        pc,          m_pc);
            chk($sformatf("rnd%0d imem_addr", c), imem_addr,   m_pc >> 2);
            chk($sformatf("rnd%0d valid", c),     {31'd0, if_id_valid}, {31'd0, m_valid});
            chk($sformatf("rnd%0d inst", c),      if_id_inst,  m_inst);
            chk($sformatf("rnd%0d if_pc", c),     if_id_pc,    m_ifpc);
            chk($sformatf("rnd%0d if_pc4", c),    if_id_pc4,   m_ifpc4);
            chk($sformatf("rnd%0d count", c),     fetch_count, m_cnt);
            chk($sformatf("rnd%0d halted", c),    {31'd0, halted}, {31'd0, m_halted});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
